// File: rtl/pc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pc_sequencer_pkg
//   Shared definitions for the program-counter / fetch sequencer.
//   - pcControl codes emitted by the control unit (the control unit imports
//     the same constants, so both sides agree on the encoding).
//   - Sequencer state encoding.
//   - Bit positions inside the registered ALU flag vector.
//   - A small helper that classifies halting pcControl codes.
// -----------------------------------------------------------------------------
package pc_sequencer_pkg;

   localparam int unsigned PC_CTRL_W = 5;

   typedef logic [PC_CTRL_W-1:0] pc_ctrl_t;

   // pcControl codes
   localparam pc_ctrl_t PC_NEXT = 5'd0;
   localparam pc_ctrl_t PC_JE   = 5'd1;
   localparam pc_ctrl_t PC_JB   = 5'd2;
   localparam pc_ctrl_t PC_JA   = 5'd3;
   localparam pc_ctrl_t PC_JNE  = 5'd4;
   localparam pc_ctrl_t PC_JBE  = 5'd5;
   localparam pc_ctrl_t PC_JAE  = 5'd6;
   localparam pc_ctrl_t PC_JNZ  = 5'd7;
   localparam pc_ctrl_t PC_JZ   = 5'd8;
   localparam pc_ctrl_t PC_JMP  = 5'd9;
   localparam pc_ctrl_t PC_HLT  = 5'd10;

   // Sequencer states
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_EXEC  = 2'd2;
   localparam logic [1:0] ST_HALT  = 2'd3;

   // Registered flag vector layout
   localparam int unsigned FLAG_EQ    = 0;
   localparam int unsigned FLAG_BELOW = 1;
   localparam int unsigned FLAG_ZERO  = 2;
   localparam int unsigned FLAG_W     = 3;

   typedef logic [FLAG_W-1:0] flags_t;

   // Every code from HLT upward stops the sequencer; only 0..9 keep running.
   function automatic logic is_halt_code(input pc_ctrl_t code);
      return (code >= PC_HLT);
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
//   Fetch handshake between the sequencer and instruction memory.
//   fetch_req  : sequencer requests the instruction at pc
//   pc         : current program counter / instruction address
//   imem_ready : memory returns the instruction for pc this cycle
//   master modport: sequencer side.  slave modport: instruction-memory side.
// -----------------------------------------------------------------------------
interface pc_sequencer_if #(
   parameter int unsigned ADDR_W = 16
);

   logic              fetch_req;
   logic [ADDR_W-1:0] pc;
   logic              imem_ready;

   modport master (
      output fetch_req,
      output pc,
      input  imem_ready
   );

   modport slave (
      input  fetch_req,
      input  pc,
      output imem_ready
   );

endinterface

// File: rtl/pc_sequencer_branch_cond.sv
// -----------------------------------------------------------------------------
// branch_cond
//   Purely combinational branch resolution.
//   pc_control : decoded pcControl code
//   flags      : registered ALU flags {zero, below, eq} (see package indices)
//   take       : 1 = load the jump target instead of pc+1
//   halt       : 1 = instruction stops the sequencer (HLT and codes 11..31)
// -----------------------------------------------------------------------------
module branch_cond
   import pc_sequencer_pkg::*;
(
   input  pc_ctrl_t pc_control,
   input  flags_t   flags,
   output logic     take,
   output logic     halt
);

   logic eq;
   logic below;
   logic zero;

   assign eq    = flags[FLAG_EQ];
   assign below = flags[FLAG_BELOW];
   assign zero  = flags[FLAG_ZERO];

   always_comb begin
      take = 1'b0;
      halt = is_halt_code(pc_control);
      case (pc_control)
         PC_JE:   take = eq;
         PC_JB:   take = below;
         PC_JA:   take = ~below & ~eq;
         PC_JNE:  take = ~eq;
         PC_JBE:  take = below | eq;
         PC_JAE:  take = ~below;
         PC_JNZ:  take = ~zero;
         PC_JZ:   take = zero;
         PC_JMP:  take = 1'b1;
         default: take = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Program counter and fetch sequencer downstream of the control unit.
//   IDLE -> FETCH (wait imem_ready) -> EXEC (one cycle) -> FETCH / HALT.
//
//   clock       : system clock, rising edge
//   reset       : asynchronous, active-low reset
//   pc_control  : control-unit pcControl code, sampled at the EXEC edge
//   jump_flag   : 1 = target from jump_reg, 0 = target from jump_imm
//   jump_imm    : instruction op2 field (immediate target)
//   jump_reg    : register value selected by op2 (indirect target)
//   alu_eq/alu_below/alu_zero : ALU compare results
//   flags_we    : capture ALU flags at the end of the current EXEC
//   resume      : leave HALT
//   fetch       : fetch handshake (fetch_req, pc out; imem_ready in)
//   instr_valid : instruction word valid this cycle (EXEC)
//   halted      : sequencer in HALT
//   retired     : retired-instruction count, wraps
// -----------------------------------------------------------------------------
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned RESET_PC = 0
) (
   input  logic                clock,
   input  logic                reset,
   input  pc_ctrl_t            pc_control,
   input  logic                jump_flag,
   input  logic [20:0]         jump_imm,
   input  logic [DATA_W-1:0]   jump_reg,
   input  logic                alu_eq,
   input  logic                alu_below,
   input  logic                alu_zero,
   input  logic                flags_we,
   input  logic                resume,
   pc_sequencer_if.master      fetch,
   output logic                instr_valid,
   output logic                halted,
   output logic [31:0]         retired
);

   localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

   logic [1:0]        state;
   logic [ADDR_W-1:0] pc_q;
   flags_t            flags_q;

   logic              take;
   logic              halt_op;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] target;

   // Target bits above ADDR_W are dropped on purpose; this keeps the whole
   // input vectors referenced so the truncation is explicit.
   logic              unused_target_bits;
   assign unused_target_bits = ^{jump_imm, jump_reg};

   // Conditions see only the registered flags, never this cycle's ALU result.
   branch_cond u_branch_cond (
      .pc_control (pc_control),
      .flags      (flags_q),
      .take       (take),
      .halt       (halt_op)
   );

   assign pc_inc = pc_q + ADDR_W'(1);
   assign target = jump_flag ? jump_reg[ADDR_W-1:0] : jump_imm[ADDR_W-1:0];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         pc_q    <= PC_RST;
         flags_q <= '0;
         retired <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               state <= ST_FETCH;
            end
            ST_FETCH: begin
               if (fetch.imem_ready) begin
                  state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               retired <= retired + 32'd1;
               pc_q    <= take ? target : pc_inc;
               // Old flags steer this branch; new ones land at the same edge.
               if (flags_we) begin
                  flags_q[FLAG_EQ]    <= alu_eq;
                  flags_q[FLAG_BELOW] <= alu_below;
                  flags_q[FLAG_ZERO]  <= alu_zero;
               end
               state <= halt_op ? ST_HALT : ST_FETCH;
            end
            ST_HALT: begin
               if (resume) begin
                  state <= ST_FETCH;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // All status outputs decode straight from the state register.
   assign fetch.fetch_req = (state == ST_FETCH);
   assign fetch.pc        = pc_q;
   assign instr_valid     = (state == ST_EXEC);
   assign halted          = (state == ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
   import pc_sequencer_pkg::*;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 32;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic [4:0]        pc_control = '0;
   logic              jump_flag = 1'b0;
   logic [20:0]       jump_imm = '0;
   logic [DATA_W-1:0] jump_reg = '0;
   logic              alu_eq = 1'b0;
   logic              alu_below = 1'b0;
   logic              alu_zero = 1'b0;
   logic              flags_we = 1'b0;
   logic              resume = 1'b0;
   logic              instr_valid;
   logic              halted;
   logic [31:0]       retired;

   int                checks = 0;
   int                errors = 0;
   int unsigned       exp_retired = 0;

   pc_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

   always #5 clock = ~clock;

   pc_sequencer #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .RESET_PC (0)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .pc_control  (pc_control),
      .jump_flag   (jump_flag),
      .jump_imm    (jump_imm),
      .jump_reg    (jump_reg),
      .alu_eq      (alu_eq),
      .alu_below   (alu_below),
      .alu_zero    (alu_zero),
      .flags_we    (flags_we),
      .resume      (resume),
      .fetch       (bus),
      .instr_valid (instr_valid),
      .halted      (halted),
      .retired     (retired)
   );

   // Branch table: flags written by NEXT rows steer the following jumps.
   localparam int NBR = 19;
   logic [4:0]  br_ctrl [NBR] = '{PC_NEXT, PC_JE, PC_NEXT, PC_JE, PC_JE, PC_JE, PC_NEXT,
                                  PC_JB, PC_JA, PC_JAE, PC_JBE, PC_JNZ, PC_JZ, PC_JNE,
                                  PC_NEXT, PC_JA, PC_JZ, PC_JNZ, PC_JAE};
   logic [20:0] br_imm  [NBR] = '{21'h0, 21'h40, 21'h0, 21'h40, 21'h80, 21'h80, 21'h0,
                                  21'h10, 21'h20, 21'h20, 21'h30, 21'h50, 21'h60, 21'h70,
                                  21'h0, 21'h20, 21'h60, 21'h50, 21'h24};
   logic [3:0]  br_fl   [NBR] = '{4'b1001, 4'b0000, 4'b1000, 4'b0000, 4'b1001, 4'b1000, 4'b1010,
                                  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                  4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
   logic [15:0] br_exp  [NBR] = '{16'h0006, 16'h0040, 16'h0041, 16'h0042, 16'h0043, 16'h0080, 16'h0081,
                                  16'h0010, 16'h0011, 16'h0012, 16'h0030, 16'h0050, 16'h0051, 16'h0070,
                                  16'h0071, 16'h0020, 16'h0060, 16'h0061, 16'h0024};

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_instr();
      pc_control = PC_NEXT;
      jump_flag  = 1'b0;
      jump_imm   = '0;
      jump_reg   = '0;
      flags_we   = 1'b0;
      alu_eq     = 1'b0;
      alu_below  = 1'b0;
      alu_zero   = 1'b0;
   endtask

   task automatic wait_exec();
      int n = 0;
      while (instr_valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (instr_valid !== 1'b1) begin
         errors++;
         $display("FAIL wait_exec: instr_valid=%b, required 1 within 20 cycles", instr_valid);
      end
   endtask

   // fl = {flags_we, zero, below, eq}
   task automatic run_instr(input logic [4:0] ctrl, input logic jf, input logic [20:0] imm,
                            input logic [31:0] rv, input logic [3:0] fl);
      wait_exec();
      pc_control = ctrl;
      jump_flag  = jf;
      jump_imm   = imm;
      jump_reg   = rv;
      flags_we   = fl[3];
      alu_zero   = fl[2];
      alu_below  = fl[1];
      alu_eq     = fl[0];
      step();
      clear_instr();
      exp_retired++;
   endtask

   task automatic test_reset();
      bus.imem_ready = 1'b1;
      #2 reset = 1'b0;
      step();
      step();
      checks++; if (bus.pc !== 16'h0000) begin errors++; $display("FAIL reset pc: got %h expected 0000", bus.pc); end
      checks++; if (bus.fetch_req !== 1'b0) begin errors++; $display("FAIL reset fetch_req: got %b expected 0", bus.fetch_req); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset instr_valid: got %b expected 0", instr_valid); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset halted: got %b expected 0", halted); end
      checks++; if (retired !== 32'd0) begin errors++; $display("FAIL reset retired: got %0d expected 0", retired); end
      reset = 1'b1;
   endtask

   task automatic test_sequential();
      // IDLE now; next edge enters FETCH
      step();
      for (int i = 0; i < 4; i++) begin
         checks++; if (bus.fetch_req !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL seq[%0d] fetch: fetch_req=%b instr_valid=%b expected 1/0", i, bus.fetch_req, instr_valid); end
         checks++; if (bus.pc !== 16'(i)) begin errors++; $display("FAIL seq[%0d] fetch pc: got %h expected %h", i, bus.pc, 16'(i)); end
         step();
         checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL seq[%0d] exec instr_valid: got %b expected 1", i, instr_valid); end
         checks++; if (bus.pc !== 16'(i)) begin errors++; $display("FAIL seq[%0d] exec pc: got %h expected %h", i, bus.pc, 16'(i)); end
         checks++; if (retired !== 32'(i)) begin errors++; $display("FAIL seq[%0d] retired: got %0d expected %0d", i, retired, i); end
         if (i == 3) bus.imem_ready = 1'b0;
         step();
      end
      exp_retired = 4;
   endtask

   task automatic test_stall();
      for (int k = 0; k < 5; k++) begin
         checks++; if (bus.fetch_req !== 1'b1 || instr_valid !== 1'b0 || bus.pc !== 16'h0004) begin
            errors++; $display("FAIL stall[%0d]: fetch_req=%b instr_valid=%b pc=%h expected 1/0/0004", k, bus.fetch_req, instr_valid, bus.pc); end
         step();
      end
      bus.imem_ready = 1'b1;
      step();
      checks++; if (instr_valid !== 1'b1 || bus.pc !== 16'h0004) begin errors++; $display("FAIL stall exec: instr_valid=%b pc=%h expected 1/0004", instr_valid, bus.pc); end
      step();
      checks++; if (instr_valid !== 1'b0 || bus.pc !== 16'h0005) begin errors++; $display("FAIL stall after: instr_valid=%b pc=%h expected 0/0005", instr_valid, bus.pc); end
      exp_retired = 5;
      checks++; if (retired !== exp_retired) begin errors++; $display("FAIL stall retired: got %0d expected %0d", retired, exp_retired); end
   endtask

   task automatic test_branch();
      for (int i = 0; i < NBR; i++) begin
         run_instr(br_ctrl[i], 1'b0, br_imm[i], 32'h0, br_fl[i]);
         checks++; if (bus.pc !== br_exp[i]) begin errors++; $display("FAIL branch[%0d] code %0d pc: got %h expected %h", i, br_ctrl[i], bus.pc, br_exp[i]); end
      end
      checks++; if (retired !== exp_retired) begin errors++; $display("FAIL branch retired: got %0d expected %0d", retired, exp_retired); end
   endtask

   task automatic test_jump_boundary();
      run_instr(PC_JMP, 1'b1, 21'h0000FF, 32'hFFFF_1234, 4'b0000);
      checks++; if (bus.pc !== 16'h1234) begin errors++; $display("FAIL jmp_reg pc: got %h expected 1234", bus.pc); end
      run_instr(PC_JMP, 1'b0, 21'h1FFFFF, 32'h0, 4'b0000);
      checks++; if (bus.pc !== 16'hFFFF) begin errors++; $display("FAIL jmp_imm_trunc pc: got %h expected ffff", bus.pc); end
      run_instr(PC_NEXT, 1'b0, 21'h0, 32'h0, 4'b0000);
      checks++; if (bus.pc !== 16'h0000) begin errors++; $display("FAIL pc_wrap pc: got %h expected 0000", bus.pc); end
   endtask

   // Flags on entry: zero=1, eq=0, below=0.
   task automatic test_halt(input logic [4:0] code);
      run_instr(PC_JMP, 1'b0, 21'h7, 32'h0, 4'b0000);
      checks++; if (bus.pc !== 16'h0007) begin errors++; $display("FAIL halt%0d setup pc: got %h expected 0007", code, bus.pc); end
      run_instr(code, 1'b0, 21'h0, 32'h0, 4'b0000);
      flags_we = 1'b1; alu_eq = 1'b1; alu_zero = 1'b0;
      for (int k = 0; k < 10; k++) begin
         checks++; if (halted !== 1'b1 || bus.fetch_req !== 1'b0 || instr_valid !== 1'b0 || bus.pc !== 16'h0008) begin
            errors++; $display("FAIL halt%0d[%0d]: halted=%b fetch_req=%b instr_valid=%b pc=%h expected 1/0/0/0008", code, k, halted, bus.fetch_req, instr_valid, bus.pc); end
         step();
      end
      checks++; if (retired !== exp_retired) begin errors++; $display("FAIL halt%0d retired: got %0d expected %0d", code, retired, exp_retired); end
      clear_instr();
      resume = 1'b1;
      step();
      resume = 1'b0;
      checks++; if (bus.fetch_req !== 1'b1 || halted !== 1'b0 || bus.pc !== 16'h0008) begin
         errors++; $display("FAIL halt%0d resume: fetch_req=%b halted=%b pc=%h expected 1/0/0008", code, bus.fetch_req, halted, bus.pc); end
      run_instr(PC_JE, 1'b0, 21'h99, 32'h0, 4'b0000);
      checks++; if (bus.pc !== 16'h0009) begin errors++; $display("FAIL halt%0d flags_we ignored (JE) pc: got %h expected 0009", code, bus.pc); end
      run_instr(PC_JZ, 1'b0, 21'h33, 32'h0, 4'b0000);
      checks++; if (bus.pc !== 16'h0033) begin errors++; $display("FAIL halt%0d flags_we ignored (JZ) pc: got %h expected 0033", code, bus.pc); end
   endtask

   task automatic test_reset_mid();
      run_instr(PC_JMP, 1'b0, 21'h22, 32'h0, 4'b0000);
      bus.imem_ready = 1'b0;
      step();
      checks++; if (bus.fetch_req !== 1'b1 || bus.pc !== 16'h0022) begin errors++; $display("FAIL midfetch setup: fetch_req=%b pc=%h expected 1/0022", bus.fetch_req, bus.pc); end
      #3 reset = 1'b0;
      #1;
      checks++; if (bus.pc !== 16'h0000 || bus.fetch_req !== 1'b0) begin errors++; $display("FAIL midfetch reset: pc=%h fetch_req=%b expected 0000/0", bus.pc, bus.fetch_req); end
      checks++; if (retired !== 32'd0) begin errors++; $display("FAIL midfetch retired: got %0d expected 0", retired); end
      step();
      reset = 1'b1;
      exp_retired = 0;
      bus.imem_ready = 1'b1;
      wait_exec();
      pc_control = PC_JMP; jump_imm = 21'h55; flags_we = 1'b1; alu_eq = 1'b1;
      #3 reset = 1'b0;
      #1;
      checks++; if (bus.pc !== 16'h0000 || instr_valid !== 1'b0 || retired !== 32'd0) begin
         errors++; $display("FAIL midexec reset: pc=%h instr_valid=%b retired=%0d expected 0000/0/0", bus.pc, instr_valid, retired); end
      clear_instr();
      step();
      reset = 1'b1;
      run_instr(PC_JE, 1'b0, 21'h40, 32'h0, 4'b0000);
      checks++; if (bus.pc !== 16'h0001) begin errors++; $display("FAIL midexec flags not written: pc=%h expected 0001", bus.pc); end
      checks++; if (retired !== 32'd1) begin errors++; $display("FAIL midexec retired after: got %0d expected 1", retired); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_branch();
      test_jump_boundary();
      test_halt(PC_HLT);
      test_halt(5'd17);
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
